// File: rtl/fill_fifo_fsm.sv
// Fetch-address generator for the HDMI pixel FIFO.
// Turns hsync / vsync / FIFO-half-empty levels into single-cycle events and
// issues one registered go_fill_fifo strobe per fetch with the DDR byte
// address to read from. Each scan line is fetched in two halves: the first
// half on the line start (prime, vsync, hsync) and the second half on a
// half-empty request.
module fill_fifo_fsm #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  hsync_I,
  input  logic                  vsync_I,
  input  logic                  fill_half_fifo_I,
  input  logic [ADDR_WIDTH-1:0] FRAME_BASE_ADDR,
  input  logic [ADDR_WIDTH-1:0] LINE_STRIDE,
  input  logic [ADDR_WIDTH-1:0] NUM_BYTES_PER_PIXEL,
  output logic [ADDR_WIDTH-1:0] ddr_addr_to_read,
  output logic                  go_fill_fifo
);

  typedef enum logic {
    StIdle,
    StRun
  } state_e;

  state_e                state_q;
  logic                  hsync_prev_q;
  logic                  vsync_prev_q;
  logic                  half_prev_q;
  logic                  pending_half_q;
  logic [ADDR_WIDTH-1:0] line_addr_q;
  logic [ADDR_WIDTH-1:0] line_bytes_q;
  logic [ADDR_WIDTH-1:0] ddr_addr_q;
  logic                  go_q;

  logic                  hsync_ev;
  logic                  vsync_ev;
  logic                  half_ev;
  logic [ADDR_WIDTH-1:0] line_bytes_in;
  logic [ADDR_WIDTH-1:0] next_line_addr;
  logic [ADDR_WIDTH-1:0] half_addr;

  // Rising-edge events and the address arithmetic (all sums wrap at ADDR_WIDTH).
  always_comb begin
    hsync_ev       = hsync_I & ~hsync_prev_q;
    vsync_ev       = vsync_I & ~vsync_prev_q;
    half_ev        = fill_half_fifo_I & ~half_prev_q;
    line_bytes_in  = LINE_STRIDE * NUM_BYTES_PER_PIXEL;
    next_line_addr = line_addr_q + line_bytes_q;
    half_addr      = line_addr_q + (line_bytes_q >> 1);
  end

  // Single state machine: edge history, line tracking, registered strobe and address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      hsync_prev_q   <= 1'b0;
      vsync_prev_q   <= 1'b0;
      half_prev_q    <= 1'b0;
      pending_half_q <= 1'b0;
      line_addr_q    <= '0;
      line_bytes_q   <= '0;
      ddr_addr_q     <= '0;
      go_q           <= 1'b0;
    end else begin
      // History tracks the inputs in every state so enabling never sees a stale edge.
      hsync_prev_q <= hsync_I;
      vsync_prev_q <= vsync_I;
      half_prev_q  <= fill_half_fifo_I;
      go_q         <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            // Prime fetch of line 0.
            line_bytes_q <= line_bytes_in;
            line_addr_q  <= FRAME_BASE_ADDR;
            ddr_addr_q   <= FRAME_BASE_ADDR;
            go_q         <= 1'b1;
            state_q      <= StRun;
          end
        end
        StRun: begin
          if (!start) begin
            pending_half_q <= 1'b0;
            state_q        <= StIdle;
          end else if (vsync_ev) begin
            line_bytes_q <= line_bytes_in;
            line_addr_q  <= FRAME_BASE_ADDR;
            ddr_addr_q   <= FRAME_BASE_ADDR;
            go_q         <= 1'b1;
            // A losing half request is deferred, not dropped.
            if (half_ev) pending_half_q <= 1'b1;
          end else if (hsync_ev) begin
            line_addr_q <= next_line_addr;
            ddr_addr_q  <= next_line_addr;
            go_q        <= 1'b1;
            if (half_ev) pending_half_q <= 1'b1;
          end else if (half_ev || pending_half_q) begin
            ddr_addr_q     <= half_addr;
            go_q           <= 1'b1;
            pending_half_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ddr_addr_to_read = ddr_addr_q;
  assign go_fill_fifo     = go_q;

endmodule

// File: tb/tb_fill_fifo_fsm.sv
// Bench for fill_fifo_fsm: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a line-number based model.
module tb_fill_fifo_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        hs = 1'b0;
  logic        vs = 1'b0;
  logic        hf = 1'b0;
  logic [31:0] fb = 32'hA800_0000;
  logic [31:0] ls = 32'h0000_0500;
  logic [31:0] nb = 32'd4;
  logic [31:0] ddr_addr;
  logic        go;

  int checks = 0;
  int failures = 0;

  fill_fifo_fsm #(.ADDR_WIDTH(32)) dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .hsync_I             (hs),
    .vsync_I             (vs),
    .fill_half_fifo_I    (hf),
    .FRAME_BASE_ADDR     (fb),
    .LINE_STRIDE         (ls),
    .NUM_BYTES_PER_PIXEL (nb),
    .ddr_addr_to_read    (ddr_addr),
    .go_fill_fifo        (go)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the fetch address is derived from the frame base, the
  // number of lines advanced since the last frame restart, and the line size.
  logic        m_run = 1'b0;
  logic        m_pend = 1'b0;
  logic        m_ph = 1'b0;
  logic        m_pv = 1'b0;
  logic        m_pf = 1'b0;
  logic        m_go = 1'b0;
  logic [31:0] m_base = '0;
  logic [31:0] m_lb = '0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_n = '0;
  logic        e_h, e_v, e_f;

  function automatic logic [31:0] line_start(input logic [31:0] base, input logic [31:0] n,
                                             input logic [31:0] lb);
    return base + n * lb;
  endfunction

  always @(posedge clk) begin
    e_h = hs & ~m_ph;
    e_v = vs & ~m_pv;
    e_f = hf & ~m_pf;
    if (reset) begin
      m_run = 0; m_pend = 0; m_ph = 0; m_pv = 0; m_pf = 0;
      m_go = 0; m_base = 0; m_lb = 0; m_addr = 0; m_n = 0;
    end else begin
      m_ph = hs; m_pv = vs; m_pf = hf;
      m_go = 0;
      if (!m_run) begin
        if (start) begin
          m_run = 1; m_base = fb; m_lb = ls * nb; m_n = 0;
          m_addr = m_base; m_go = 1;
        end
      end else if (!start) begin
        m_run = 0; m_pend = 0;
      end else if (e_v || e_h) begin
        if (e_v) begin
          m_base = fb; m_lb = ls * nb; m_n = 0;
        end else begin
          m_n = m_n + 1;
        end
        m_addr = line_start(m_base, m_n, m_lb);
        m_go = 1;
        if (e_f) m_pend = 1;
      end else if (e_f || m_pend) begin
        m_addr = line_start(m_base, m_n, m_lb) + (m_lb >> 1);
        m_go = 1; m_pend = 0;
      end
    end
    #1;
    chk("model_go", {31'b0, go}, {31'b0, m_go});
    chk("model_addr", ddr_addr, m_addr);
  end

  task automatic expect_pulse(input string name, input logic [31:0] addr);
    @(posedge clk);
    #2;
    chk({name, "_go"}, {31'b0, go}, 32'd1);
    chk({name, "_addr"}, ddr_addr, addr);
  endtask

  task automatic count_pulses(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(posedge clk);
      #2;
      cnt += int'(go);
    end
  endtask

  initial begin
    int cnt;
    // 1. Reset state and prime fetch.
    @(negedge clk);
    @(negedge clk);
    chk("reset_go", {31'b0, go}, 32'd0);
    chk("reset_addr", ddr_addr, 32'd0);
    reset = 0;
    start = 1;
    expect_pulse("prime", 32'hA800_0000);
    count_pulses(1, cnt);
    chk("prime_single", cnt, 0);

    // 2. Seven line advances.
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      hs = 1;
      expect_pulse("hsync", 32'hA800_0000 + 32'(i) * 32'h1400);
      @(negedge clk);
      hs = 0;
      @(negedge clk);
    end

    // 3. Frame restart, then line 1.
    @(negedge clk); vs = 1;
    expect_pulse("vsync", 32'hA800_0000);
    @(negedge clk); vs = 0;
    @(negedge clk); hs = 1;
    expect_pulse("line1", 32'hA800_1400);
    @(negedge clk); hs = 0;

    // 4. Half request held high gives one fetch.
    @(negedge clk); hf = 1;
    expect_pulse("half", 32'hA800_1E00);
    count_pulses(4, cnt);
    chk("half_held", cnt, 0);
    @(negedge clk); hf = 0;

    // 5. Collisions.
    @(negedge clk); vs = 1;
    expect_pulse("vsync2", 32'hA800_0000);
    @(negedge clk); vs = 0;
    @(negedge clk); hs = 1; hf = 1;
    expect_pulse("coll_h", 32'hA800_1400);
    expect_pulse("coll_pend", 32'hA800_1E00);
    @(negedge clk); hs = 0; hf = 0;
    @(negedge clk); vs = 1; hs = 1;
    expect_pulse("coll_vh", 32'hA800_0000);
    count_pulses(3, cnt);
    chk("coll_vh_single", cnt, 0);
    @(negedge clk); vs = 0; hs = 0;

    // 6. Reset mid-RUN, stop, restart.
    @(negedge clk); hs = 1;
    expect_pulse("pre_rst", 32'hA800_1400);
    reset = 1;
    #1;
    chk("async_rst_go", {31'b0, go}, 32'd0);
    chk("async_rst_addr", ddr_addr, 32'd0);
    @(negedge clk); hs = 0;
    @(negedge clk); reset = 0;
    expect_pulse("after_rst", 32'hA800_0000);
    @(negedge clk); start = 0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); hs = 1;
      @(negedge clk); hs = 0;
    end
    count_pulses(2, cnt);
    chk("stopped", cnt, 0);
    @(negedge clk); start = 1;
    expect_pulse("restart", 32'hA800_0000);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      hs = ($urandom_range(0, 3) == 0);
      hf = ($urandom_range(0, 3) == 0);
      vs = ($urandom_range(0, 15) == 0);
      start = ($urandom_range(0, 40) != 0);
      reset = ($urandom_range(0, 250) == 0);
      if ($urandom_range(0, 20) == 0) begin
        fb = $urandom();
        ls = $urandom_range(1, 4096);
        nb = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(1, 4));
      end
    end
    @(negedge clk);
    reset = 0; hs = 0; vs = 0; hf = 0;
    @(negedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
